// File: rtl/vec_mul_seq_ctrl.sv
// Vector-multiply pass sequencer: pops a weight tile, loads the PE weights, streams
// input-SRAM reads and emits result-SRAM writes delayed by the array's output latency.
module vec_mul_seq_ctrl #(
    parameter int ADDRESSSIZE = 10,
    parameter int PIPE_LAT    = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] num_rows,
    input  logic [ADDRESSSIZE-1:0] in_base,
    input  logic [ADDRESSSIZE-1:0] out_base,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   we_rl,
    output logic [ADDRESSSIZE-1:0] sram_rd_addr,
    output logic                   sram_rd_valid,
    output logic                   res_wr_en,
    output logic [ADDRESSSIZE-1:0] res_wr_addr,
    output logic                   busy,
    output logic                   end_,
    output logic                   err
);

    typedef enum logic [2:0] {IDLE, WPOP, WLOAD, FEED, DRAIN, DONE} state_t;

    state_t                 state;
    logic [ADDRESSSIZE-1:0] n_rows;
    logic [ADDRESSSIZE-1:0] in_base_q;
    logic [ADDRESSSIZE-1:0] out_base_q;
    logic [ADDRESSSIZE-1:0] rd_cnt;
    logic [ADDRESSSIZE-1:0] wr_cnt;
    logic [PIPE_LAT-1:0]    dly;
    logic [PIPE_LAT:0]      taps;

    // taps[0] is the registered read strobe; taps[PIPE_LAT] is the write strobe itself,
    // so taps[PIPE_LAT-1] announces a write one cycle ahead for the address register.
    assign taps      = {dly, sram_rd_valid};
    assign res_wr_en = dly[PIPE_LAT-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            n_rows        <= '0;
            in_base_q     <= '0;
            out_base_q    <= '0;
            rd_cnt        <= '0;
            fifo_rd_en    <= 1'b0;
            we_rl         <= 1'b0;
            sram_rd_addr  <= '0;
            sram_rd_valid <= 1'b0;
            busy          <= 1'b0;
            end_          <= 1'b0;
            err           <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register here sees the pre-edge value of every other register.
            fifo_rd_en <= 1'b0;
            we_rl      <= 1'b0;
            end_       <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (fifo_empty || num_rows == '0) begin
                            err <= 1'b1;
                        end else begin
                            n_rows     <= num_rows;
                            in_base_q  <= in_base;
                            out_base_q <= out_base;
                            fifo_rd_en <= 1'b1;
                            busy       <= 1'b1;
                            state      <= WPOP;
                        end
                    end
                end
                WPOP: begin
                    we_rl <= 1'b1;
                    state <= WLOAD;
                end
                WLOAD: begin
                    sram_rd_valid <= 1'b1;
                    sram_rd_addr  <= in_base_q;
                    rd_cnt        <= ADDRESSSIZE'(1);
                    state         <= FEED;
                end
                FEED: begin
                    if (rd_cnt == n_rows) begin
                        sram_rd_valid <= 1'b0;
                        state         <= DRAIN;
                    end else begin
                        sram_rd_addr <= in_base_q + rd_cnt;
                        rd_cnt       <= rd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // wr_cnt hits n while the last write is on the bus, so end_ follows it directly
                    if (wr_cnt == n_rows) begin
                        end_  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the delay line is reset, unlike a data memory, because a stale
            // strobe surviving an abort would issue a spurious result write.
            dly         <= '0;
            wr_cnt      <= '0;
            res_wr_addr <= '0;
        end else begin
            dly <= taps[PIPE_LAT-1:0];
            if (state == IDLE) begin
                wr_cnt <= '0;
            end else if (taps[PIPE_LAT-1]) begin
                res_wr_addr <= out_base_q + wr_cnt;
                wr_cnt      <= wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vec_mul_seq_ctrl.sv
// Scoreboard bench: two sequencers (latency 10 and 1) share stimulus; a cycle-based
// reference model queues expected strobes, a monitor compares them every cycle.
module tb_vec_mul_seq_ctrl;

    localparam int AW  = 10;
    localparam int PL0 = 10;
    localparam int PL1 = 1;

    typedef struct {
        int unsigned   cyc;
        logic [AW-1:0] addr;
    } ev_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start = 1'b0;
    logic [AW-1:0] num_rows = '0;
    logic [AW-1:0] in_base = '0;
    logic [AW-1:0] out_base = '0;
    logic          fifo_empty = 1'b0;

    logic          pop_o [2];
    logic          wl_o  [2];
    logic          rdv_o [2];
    logic          wre_o [2];
    logic          busy_o[2];
    logic          end_o [2];
    logic          err_o [2];
    logic [AW-1:0] rda_o [2];
    logic [AW-1:0] wra_o [2];

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    ev_t         q_pop[2][$];
    ev_t         q_wl [2][$];
    ev_t         q_rd [2][$];
    ev_t         q_wr [2][$];
    ev_t         q_end[2][$];
    ev_t         q_err[2][$];
    int unsigned last_end[2] = '{0, 0};
    int unsigned busy_lo [2] = '{1, 1};
    int unsigned busy_hi [2] = '{0, 0};

    vec_mul_seq_ctrl #(.ADDRESSSIZE(AW), .PIPE_LAT(PL0)) u0 (
        .clk(clk), .rstn(rstn), .start(start), .num_rows(num_rows),
        .in_base(in_base), .out_base(out_base), .fifo_empty(fifo_empty),
        .fifo_rd_en(pop_o[0]), .we_rl(wl_o[0]), .sram_rd_addr(rda_o[0]),
        .sram_rd_valid(rdv_o[0]), .res_wr_en(wre_o[0]), .res_wr_addr(wra_o[0]),
        .busy(busy_o[0]), .end_(end_o[0]), .err(err_o[0])
    );

    vec_mul_seq_ctrl #(.ADDRESSSIZE(AW), .PIPE_LAT(PL1)) u1 (
        .clk(clk), .rstn(rstn), .start(start), .num_rows(num_rows),
        .in_base(in_base), .out_base(out_base), .fifo_empty(fifo_empty),
        .fifo_rd_en(pop_o[1]), .we_rl(wl_o[1]), .sram_rd_addr(rda_o[1]),
        .sram_rd_valid(rdv_o[1]), .res_wr_en(wre_o[1]), .res_wr_addr(wra_o[1]),
        .busy(busy_o[1]), .end_(end_o[1]), .err(err_o[1])
    );

    always #5 clk = ~clk;

    // cyc is the index of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string what, input int j, input int unsigned cur,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL u%0d %s cycle %0d: got %0h expected %0h", j, what, cur, act, exp);
        end
    endtask

    function automatic ev_t mk(input int unsigned c, input int a);
        ev_t e;
        e.cyc  = c;
        e.addr = AW'(a % (1 << AW));
        return e;
    endfunction

    // A start sampled at edge t0 is taken only if the unit is idle, i.e. its last end_ cycle is past.
    task automatic model_start(input int unsigned t0, input int n, input int ib, input int ob,
                               input bit empty);
        for (int j = 0; j < 2; j++) begin
            int unsigned pl;
            pl = (j == 0) ? PL0 : PL1;
            if (t0 <= last_end[j]) continue;
            if (empty || n == 0) begin
                q_err[j].push_back(mk(t0 + 1, 0));
                continue;
            end
            q_pop[j].push_back(mk(t0 + 1, 0));
            q_wl[j].push_back(mk(t0 + 2, 0));
            for (int i = 0; i < n; i++) begin
                q_rd[j].push_back(mk(t0 + 3 + i, ib + i));
                q_wr[j].push_back(mk(t0 + 3 + pl + i, ob + i));
            end
            q_end[j].push_back(mk(t0 + 3 + n + pl, 0));
            last_end[j] = t0 + 3 + n + pl;
            busy_lo[j]  = t0 + 1;
            busy_hi[j]  = last_end[j];
        end
    endtask

    task automatic model_flush();
        for (int j = 0; j < 2; j++) begin
            q_pop[j].delete();
            q_wl[j].delete();
            q_rd[j].delete();
            q_wr[j].delete();
            q_end[j].delete();
            q_err[j].delete();
            last_end[j] = 0;
            busy_lo[j]  = 1;
            busy_hi[j]  = 0;
        end
    endtask

    // Called at a falling edge; start is seen by the next rising edge.
    task automatic do_start(input int n, input int ib, input int ob, input bit empty,
                            output int unsigned t0);
        t0         = cyc + 1;
        start      = 1'b1;
        num_rows   = AW'(n);
        in_base    = AW'(ib);
        out_base   = AW'(ob);
        fifo_empty = empty;
        if (rstn) model_start(t0, n, ib, ob, empty);
        @(negedge clk);
        start      = 1'b0;
        num_rows   = AW'($urandom);
        in_base    = AW'($urandom);
        out_base   = AW'($urandom);
        fifo_empty = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int unsigned lim;
        lim = ((last_end[0] > last_end[1]) ? last_end[0] : last_end[1]) + 1;
        while (cyc < lim) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        for (int j = 0; j < 2; j++) begin
            check({tag, " fifo_rd_en"}, j, cyc, 32'(pop_o[j]), 0);
            check({tag, " we_rl"}, j, cyc, 32'(wl_o[j]), 0);
            check({tag, " sram_rd_valid"}, j, cyc, 32'(rdv_o[j]), 0);
            check({tag, " sram_rd_addr"}, j, cyc, 32'(rda_o[j]), 0);
            check({tag, " res_wr_en"}, j, cyc, 32'(wre_o[j]), 0);
            check({tag, " res_wr_addr"}, j, cyc, 32'(wra_o[j]), 0);
            check({tag, " busy"}, j, cyc, 32'(busy_o[j]), 0);
            check({tag, " end_"}, j, cyc, 32'(end_o[j]), 0);
            check({tag, " err"}, j, cyc, 32'(err_o[j]), 0);
        end
    endtask

    // Monitor: at each falling edge compare every strobe with the head of its queue.
    always @(negedge clk) begin
        int unsigned cur;
        logic        e;
        cur = cyc + 1;
        for (int j = 0; j < 2; j++) begin
            e = (q_pop[j].size() != 0) && (q_pop[j][0].cyc == cur);
            check("fifo_rd_en", j, cur, 32'(pop_o[j]), 32'(e));
            if (e) void'(q_pop[j].pop_front());

            e = (q_wl[j].size() != 0) && (q_wl[j][0].cyc == cur);
            check("we_rl", j, cur, 32'(wl_o[j]), 32'(e));
            if (e) void'(q_wl[j].pop_front());

            e = (q_rd[j].size() != 0) && (q_rd[j][0].cyc == cur);
            check("sram_rd_valid", j, cur, 32'(rdv_o[j]), 32'(e));
            if (e) begin
                check("sram_rd_addr", j, cur, 32'(rda_o[j]), 32'(q_rd[j][0].addr));
                void'(q_rd[j].pop_front());
            end

            e = (q_wr[j].size() != 0) && (q_wr[j][0].cyc == cur);
            check("res_wr_en", j, cur, 32'(wre_o[j]), 32'(e));
            if (e) begin
                check("res_wr_addr", j, cur, 32'(wra_o[j]), 32'(q_wr[j][0].addr));
                void'(q_wr[j].pop_front());
            end

            e = (q_end[j].size() != 0) && (q_end[j][0].cyc == cur);
            check("end_", j, cur, 32'(end_o[j]), 32'(e));
            if (e) void'(q_end[j].pop_front());

            e = (q_err[j].size() != 0) && (q_err[j][0].cyc == cur);
            check("err", j, cur, 32'(err_o[j]), 32'(e));
            if (e) void'(q_err[j].pop_front());

            e = (cur >= busy_lo[j]) && (cur <= busy_hi[j]);
            check("busy", j, cur, 32'(busy_o[j]), 32'(e));
        end
    end

    initial begin
        int unsigned t;
        int unsigned le;
        int          n;
        int          ib;
        int          ob;
        bit          empty;

        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 rstn = 1'b1;
        @(negedge clk);

        // basic pass
        do_start(8, 0, 0, 1'b0, t);
        wait_idle();
        repeat (2) @(negedge clk);

        // rejected starts: empty FIFO, then zero rows, then back-to-back rejections
        do_start(5, 3, 4, 1'b1, t);
        do_start(0, 3, 4, 1'b0, t);
        repeat (2) @(negedge clk);

        // address wrap
        do_start(4, 1022, 1023, 1'b0, t);
        wait_idle();

        // starts while busy (FEED, then DRAIN of the long-latency unit)
        do_start(6, 100, 200, 1'b0, t);
        while (cyc != t + 4) @(negedge clk);
        do_start(3, 7, 9, 1'b1, le);
        do_start(3, 7, 9, 1'b0, le);
        while (cyc != t + 12) @(negedge clk);
        do_start(3, 50, 60, 1'b0, le);
        wait_idle();

        // back-to-back: start during end_ cycle is ignored, start right after is taken
        do_start(5, 10, 20, 1'b0, t);
        le = last_end[0];
        while (cyc != le - 1) @(negedge clk);
        do_start(4, 30, 40, 1'b0, t);
        do_start(4, 300, 400, 1'b0, t);
        wait_idle();

        // asynchronous reset while row 3 is being read
        do_start(8, 0, 0, 1'b0, t);
        while (cyc != t + 5) @(negedge clk);
        #2 rstn = 1'b0;
        model_flush();
        #1 check_all_zero("abort");
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (25) @(negedge clk);
        do_start(8, 0, 0, 1'b0, t);
        wait_idle();

        // single row
        do_start(1, 500, 600, 1'b0, t);
        wait_idle();

        // random traffic, including starts landing while busy
        for (int k = 0; k < 40; k++) begin
            n     = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
            ib    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1015, 1023)) : int'($urandom_range(0, 1023));
            ob    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1015, 1023)) : int'($urandom_range(0, 1023));
            empty = ($urandom_range(0, 7) == 0);
            do_start(n, ib, ob, empty, t);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 25)) @(negedge clk);
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);

        for (int j = 0; j < 2; j++) begin
            check("pending fifo_rd_en", j, cyc, 32'(q_pop[j].size()), 0);
            check("pending we_rl", j, cyc, 32'(q_wl[j].size()), 0);
            check("pending reads", j, cyc, 32'(q_rd[j].size()), 0);
            check("pending writes", j, cyc, 32'(q_wr[j].size()), 0);
            check("pending end_", j, cyc, 32'(q_end[j].size()), 0);
            check("pending err", j, cyc, 32'(q_err[j].size()), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
